// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM: per-cycle round-robin grant,
// lock ownership with idle timeout, and read-return routing on the RAM's one-cycle latency.
module onchip_memory_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             rd_pend, rd_owner;
  logic             req0, req1, gnt0, gnt1, sel;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    idle_cnt_nxt   = idle_cnt;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    case (state)
      ARB: begin
        // last_grant names the master that won most recently; the other one wins a tie.
        if (req0 && req1) begin
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        idle_cnt_nxt = '0;
        if (gnt0 && m0_lock)      state_nxt = OWN0;
        else if (gnt1 && m1_lock) state_nxt = OWN1;
      end
      OWN0: begin
        gnt0 = req0;
        if (req0) begin
          idle_cnt_nxt = '0;
          if (!m0_lock) state_nxt = ARB;
        end else if (idle_cnt == IDLE_LAST) begin
          idle_cnt_nxt = '0;
          state_nxt    = ARB;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      OWN1: begin
        gnt1 = req1;
        if (req1) begin
          idle_cnt_nxt = '0;
          if (!m1_lock) state_nxt = ARB;
        end else if (idle_cnt == IDLE_LAST) begin
          idle_cnt_nxt = '0;
          state_nxt    = ARB;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
    if (gnt0)      last_grant_nxt = 1'b0;
    else if (gnt1) last_grant_nxt = 1'b1;
  end

  // RAM side: reset masks the combinational grant so nothing reaches the RAM while held.
  assign sel            = gnt1;
  assign mem_clken      = ~reset;
  assign mem_chipselect = (gnt0 | gnt1) & ~reset;
  assign mem_write      = mem_chipselect & (sel ? m1_write : m0_write);
  assign mem_address    = sel ? m1_address : m0_address;
  assign mem_byteenable = mem_write ? (sel ? m1_byteenable : m0_byteenable) : '1;
  assign mem_writedata  = sel ? m1_writedata : m0_writedata;

  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= 1'b1;
      idle_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      idle_cnt   <= idle_cnt_nxt;
      rd_pend    <= mem_chipselect & ~mem_write;
      rd_owner   <= sel;
    end
  end

  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule
